node_port_ctrl: RTL and testbench

- Node-side endpoint of the multipoint interposer arbitration protocol, one instance per node.
- Queues outbound packets from the local core and presents a 4-bit request {on, dest[2:0]} to the central arbiter.
- Consumes the arbiter's 3-bit {Tx, Rx, Bp} control, then drives, captures or forwards the shared link segment.

---
 rtl/interposer_pkg.sv | 29 ++
 rtl/node_port_ctrl_if.sv | 49 ++++
 rtl/node_tx_fifo.sv | 52 +++++
 rtl/node_port_ctrl.sv | 164 ++++++++++++++++
 tb/tb_node_port_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/interposer_pkg.sv
// Shared definitions for the interposer arbitration protocol: control bit
// positions, request field layout, link word format and node FSM states.
package interposer_pkg;

  localparam int CTL_TX = 2;
  localparam int CTL_RX = 1;
  localparam int CTL_BP = 0;

  localparam int DEST_W     = 3;
  localparam int DATA_W     = 32;
  localparam int REQ_ON_BIT = DEST_W;

  typedef struct packed {
    logic [DEST_W-1:0] src;
    logic [DATA_W-1:0] data;
  } link_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } port_state_t;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/node_port_ctrl_if.sv
// Bundle of the node port's core, arbiter and link signals.
// Optional statistics outputs appear when NODE_PORT_STATS_EN is defined.
interface node_port_ctrl_if #(
  parameter int DEST_W = 3,
  parameter int DATA_W = 32
);
  logic                     tx_valid;
  logic                     tx_ready;
  logic [DEST_W-1:0]        tx_dest;
  logic [DATA_W-1:0]        tx_data;
  logic [DEST_W:0]          request_out;
  logic [2:0]               control_in;
  logic [DEST_W+DATA_W-1:0] link_in;
  logic                     link_in_valid;
  logic [DEST_W+DATA_W-1:0] link_out;
  logic                     link_out_valid;
  logic                     rx_valid;
  logic [DEST_W-1:0]        rx_src;
  logic [DATA_W-1:0]        rx_data;
  logic                     drop_self;
  logic                     starve;
  logic                     protocol_err;
`ifdef NODE_PORT_STATS_EN
  logic [15:0]              stat_sent;
  logic [15:0]              stat_recv;
  logic [15:0]              stat_bypass;
  logic [15:0]              stat_drop;
`endif

  // Core, arbiter and upstream link side.
  modport master (
`ifdef NODE_PORT_STATS_EN
    input  stat_sent, stat_recv, stat_bypass, stat_drop,
`endif
    output tx_valid, tx_dest, tx_data, control_in, link_in, link_in_valid,
    input  tx_ready, request_out, link_out, link_out_valid,
    input  rx_valid, rx_src, rx_data, drop_self, starve, protocol_err
  );

  // Node port controller side.
  modport slave (
`ifdef NODE_PORT_STATS_EN
    output stat_sent, stat_recv, stat_bypass, stat_drop,
`endif
    input  tx_valid, tx_dest, tx_data, control_in, link_in, link_in_valid,
    output tx_ready, request_out, link_out, link_out_valid,
    output rx_valid, rx_src, rx_data, drop_self, starve, protocol_err
  );
endinterface

// File: rtl/node_tx_fifo.sv
// Outbound packet queue: synchronous FIFO with registered occupancy.
// The head entry is read asynchronously so the controller always sees it.
module node_tx_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != (PTR_W+1)'(DEPTH)) || do_pop);

  // Storage write; contents need no reset since occupancy gates use.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);
endmodule

// File: rtl/node_port_ctrl.sv
// Node-side endpoint of the interposer arbitration protocol: queues core
// packets, requests the link, and transmits/receives/bypasses per arbiter
// control. Define NODE_PORT_STATS_EN to add saturating traffic counters.
module node_port_ctrl #(
  parameter int NODE_ID       = 0,
  parameter int NODE_COUNT    = 8,
  parameter int DEST_W        = 3,
  parameter int DATA_W        = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_CYCLES = 64
) (
  input logic             clk,
  input logic             reset,
  node_port_ctrl_if.slave bus
);
  import interposer_pkg::*;

  localparam int LINK_W = DEST_W + DATA_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W  = $clog2(STARVE_CYCLES + 1);
  localparam logic [DEST_W-1:0] SELF_ID = DEST_W'(NODE_ID % NODE_COUNT);

  port_state_t       state_reg, state_next;
  logic [LINK_W-1:0] head;
  logic [CNT_W-1:0]  occ;
  logic              full, empty, accept, push, pop;
  logic              ctl_multi, ctl_tx, ctl_rx, ctl_bp, grant, err;

  logic [LINK_W-1:0] link_out_reg;
  logic              link_out_valid_reg, rx_valid_reg, drop_reg;
  logic [DEST_W-1:0] rx_src_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              starve_reg, perr_reg;
  logic [STV_W-1:0]  wait_reg;

  assign accept = bus.tx_valid && !full;
  assign push   = accept && (bus.tx_dest != SELF_ID);
  assign pop    = (state_reg == ST_SEND);

  node_tx_fifo #(.WIDTH(LINK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({bus.tx_dest, bus.tx_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  // Only a one-hot control word is a legal command.
  assign ctl_multi = (bus.control_in[CTL_TX] & bus.control_in[CTL_RX]) |
                     (bus.control_in[CTL_TX] & bus.control_in[CTL_BP]) |
                     (bus.control_in[CTL_RX] & bus.control_in[CTL_BP]);
  assign ctl_tx = bus.control_in[CTL_TX] && !ctl_multi;
  assign ctl_rx = bus.control_in[CTL_RX] && !ctl_multi;
  assign ctl_bp = bus.control_in[CTL_BP] && !ctl_multi;
  assign grant  = ctl_tx && (state_reg == ST_REQ);
  assign err    = ctl_multi || (ctl_tx && (state_reg != ST_REQ)) ||
                  (ctl_rx && (bus.link_in[LINK_W-1 -: DEST_W] == SELF_ID));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state: request while queued, send one packet per grant.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (!empty) state_next = ST_REQ;
      ST_REQ:  if (grant)  state_next = ST_SEND;
      ST_SEND: state_next = ((occ > CNT_W'(1)) || push) ? ST_REQ : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Link and delivery outputs, one cycle after the sampled control word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      link_out_reg       <= '0;
      link_out_valid_reg <= 1'b0;
      rx_valid_reg       <= 1'b0;
      rx_src_reg         <= '0;
      rx_data_reg        <= '0;
      perr_reg           <= 1'b0;
    end else begin
      link_out_valid_reg <= 1'b0;
      rx_valid_reg       <= 1'b0;
      if (err) begin
        perr_reg <= 1'b1;
      end else if (grant) begin
        link_out_reg       <= {SELF_ID, head[DATA_W-1:0]};
        link_out_valid_reg <= 1'b1;
      end else if (ctl_rx && bus.link_in_valid) begin
        rx_valid_reg <= 1'b1;
        rx_src_reg   <= bus.link_in[LINK_W-1 -: DEST_W];
        rx_data_reg  <= bus.link_in[DATA_W-1:0];
      end else if (ctl_bp) begin
        link_out_reg       <= bus.link_in;
        link_out_valid_reg <= bus.link_in_valid;
      end
    end
  end

  // Self-addressed packets are discarded and flagged for one cycle.
  always_ff @(posedge clk) begin
    if (!reset) drop_reg <= 1'b0;
    else        drop_reg <= accept && (bus.tx_dest == SELF_ID);
  end

  // Starvation watchdog over ungranted request cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_reg   <= '0;
      starve_reg <= 1'b0;
    end else if (grant) begin
      wait_reg   <= '0;
      starve_reg <= 1'b0;
    end else if (state_reg == ST_REQ) begin
      if (wait_reg != STV_W'(STARVE_CYCLES)) wait_reg <= wait_reg + 1'b1;
      if (wait_reg >= STV_W'(STARVE_CYCLES - 1)) starve_reg <= 1'b1;
    end else begin
      wait_reg <= '0;
    end
  end

  assign bus.tx_ready       = !full;
  assign bus.request_out    = (state_reg == ST_REQ) ? {1'b1, head[LINK_W-1 -: DEST_W]} : '0;
  assign bus.link_out       = link_out_reg;
  assign bus.link_out_valid = link_out_valid_reg;
  assign bus.rx_valid       = rx_valid_reg;
  assign bus.rx_src         = rx_src_reg;
  assign bus.rx_data        = rx_data_reg;
  assign bus.drop_self      = drop_reg;
  assign bus.starve         = starve_reg;
  assign bus.protocol_err   = perr_reg;

`ifdef NODE_PORT_STATS_EN
  logic [15:0] sent_reg, recv_reg, bypass_reg, dropcnt_reg;

  // Saturating traffic counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sent_reg    <= '0;
      recv_reg    <= '0;
      bypass_reg  <= '0;
      dropcnt_reg <= '0;
    end else begin
      if (state_reg == ST_SEND)        sent_reg    <= sat_inc16(sent_reg);
      if (rx_valid_reg)                recv_reg    <= sat_inc16(recv_reg);
      if (ctl_bp && bus.link_in_valid) bypass_reg  <= sat_inc16(bypass_reg);
      if (drop_reg)                    dropcnt_reg <= sat_inc16(dropcnt_reg);
    end
  end

  assign bus.stat_sent   = sent_reg;
  assign bus.stat_recv   = recv_reg;
  assign bus.stat_bypass = bypass_reg;
  assign bus.stat_drop   = dropcnt_reg;
`endif
endmodule

// File: tb/tb_node_port_ctrl.sv
// Directed bench for node_port_ctrl at NODE_ID=2 with a queue-based model
// compared every cycle, plus literal expectations at key points.
module tb_node_port_ctrl;
  localparam int ID    = 2;
  localparam int DEPTH = 4;
  localparam int STV   = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  node_port_ctrl_if #(.DEST_W(3), .DATA_W(32)) bus ();

  node_port_ctrl #(
    .NODE_ID(ID), .NODE_COUNT(8), .DEST_W(3), .DATA_W(32),
    .FIFO_DEPTH(DEPTH), .STARVE_CYCLES(STV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [34:0] mq[$];
  int          m_phase;   // 0 idle, 1 requesting, 2 sending
  int          m_wait;
  int          m_next;
  bit          chk_en = 1'b0;
  bit          m_acc, m_push, m_grant, m_err;
  logic [2:0]  m_ctl;
  logic [3:0]  e_req;
  logic        e_ready, e_lov, e_rxv, e_drop, e_starve, e_perr;
  logic [34:0] e_lo;
  logic [2:0]  e_rxs;
  logic [31:0] e_rxd;

  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_phase = 0; m_wait = 0;
      e_lo = '0; e_lov = 0; e_rxv = 0; e_rxs = '0; e_rxd = '0;
      e_drop = 0; e_starve = 0; e_perr = 0;
      chk_en = 1'b1;
    end else begin
      m_ctl   = bus.control_in;
      m_acc   = bus.tx_valid && (mq.size() < DEPTH);
      m_push  = m_acc && (bus.tx_dest != 3'(ID));
      m_grant = (m_ctl == 3'b100) && (m_phase == 1);
      m_err   = ($countones(m_ctl) > 1) || ((m_ctl == 3'b100) && (m_phase != 1)) ||
                ((m_ctl == 3'b010) && (bus.link_in[34:32] == 3'(ID)));
      e_lov = 0; e_rxv = 0;
      if (m_err) e_perr = 1;
      else if (m_ctl == 3'b100) begin
        e_lo = {3'(ID), mq[0][31:0]}; e_lov = 1;
      end else if (m_ctl == 3'b010) begin
        if (bus.link_in_valid) begin
          e_rxv = 1; e_rxs = bus.link_in[34:32]; e_rxd = bus.link_in[31:0];
        end
      end else if (m_ctl == 3'b001) begin
        e_lo = bus.link_in; e_lov = bus.link_in_valid;
      end
      if (m_grant) begin
        m_wait = 0; e_starve = 0;
      end else if (m_phase == 1) begin
        if (m_wait < STV) m_wait++;
        if (m_wait == STV) e_starve = 1;
      end else m_wait = 0;
      case (m_phase)
        0: m_next = (mq.size() > 0) ? 1 : 0;
        1: m_next = m_grant ? 2 : 1;
        default: m_next = ((mq.size() - 1 + int'(m_push)) > 0) ? 1 : 0;
      endcase
      if (m_phase == 2) void'(mq.pop_front());
      if (m_push) mq.push_back({bus.tx_dest, bus.tx_data});
      e_drop  = m_acc && (bus.tx_dest == 3'(ID));
      m_phase = m_next;
    end
    e_req   = (m_phase == 1) ? {1'b1, mq[0][34:32]} : 4'd0;
    e_ready = (mq.size() < DEPTH);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_ready", 64'(bus.tx_ready), 64'(e_ready));
      check("request_out", 64'(bus.request_out), 64'(e_req));
      check("link_out_valid", 64'(bus.link_out_valid), 64'(e_lov));
      check("link_out", 64'(bus.link_out), 64'(e_lo));
      check("rx_valid", 64'(bus.rx_valid), 64'(e_rxv));
      check("rx_src", 64'(bus.rx_src), 64'(e_rxs));
      check("rx_data", 64'(bus.rx_data), 64'(e_rxd));
      check("drop_self", 64'(bus.drop_self), 64'(e_drop));
      check("starve", 64'(bus.starve), 64'(e_starve));
      check("protocol_err", 64'(bus.protocol_err), 64'(e_perr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [2:0] d, input logic [31:0] v);
    bus.tx_valid = 1'b1; bus.tx_dest = d; bus.tx_data = v;
    $display("push dest=%0d data=0x%08h ready=%0b", d, v, bus.tx_ready);
    step();
    bus.tx_valid = 1'b0;
  endtask

  task automatic grant_once();
    bus.control_in = 3'b100;
    $display("grant request=0x%0h", bus.request_out);
    step();
    bus.control_in = 3'b000;
  endtask

  initial begin
    reset = 1'b0;
    bus.tx_valid = 0; bus.tx_dest = '0; bus.tx_data = '0;
    bus.control_in = '0; bus.link_in = '0; bus.link_in_valid = 0;
    step(); step();
    check("reset tx_ready", 64'(bus.tx_ready), 64'd1);
    check("reset request_out", 64'(bus.request_out), 64'd0);
    reset = 1'b1;
    step();

    // Single packet: request, grant, send, back to idle.
    push(3'd5, 32'hA5A5_0001);
    step(); step(); step();
    check("req raised", 64'(bus.request_out), 64'hD);
    grant_once();
    check("send link_out", 64'(bus.link_out), {29'd0, 3'd2, 32'hA5A5_0001});
    check("send valid", 64'(bus.link_out_valid), 64'd1);
    check("send req low", 64'(bus.request_out), 64'd0);
    step();
    check("idle req", 64'(bus.request_out), 64'd0);

    // Fill the queue; a fifth offer waits until space frees.
    push(3'd1, 32'h1); push(3'd3, 32'h3); push(3'd4, 32'h4); push(3'd7, 32'h7);
    check("full tx_ready", 64'(bus.tx_ready), 64'd0);
    check("full req", 64'(bus.request_out), 64'h9);
    bus.tx_valid = 1'b1; bus.tx_dest = 3'd6; bus.tx_data = 32'h55;
    $display("offer dest=6 data=0x00000055 while full");
    step();
    check("5th blocked", 64'(bus.tx_ready), 64'd0);
    bus.control_in = 3'b100;
    $display("grant with full queue");
    step();
    bus.control_in = 3'b000;
    step();
    check("re-raise req", 64'(bus.request_out), 64'hB);
    step();
    bus.tx_valid = 1'b0;
    check("refilled", 64'(bus.tx_ready), 64'd0);

    // Bypass.
    bus.control_in = 3'b001; bus.link_in = {3'd6, 32'h1234}; bus.link_in_valid = 1;
    $display("bypass src=6 data=0x1234");
    step();
    check("bp link_out", 64'(bus.link_out), {29'd0, 3'd6, 32'h1234});
    check("bp valid", 64'(bus.link_out_valid), 64'd1);
    check("bp occ", 64'(bus.tx_ready), 64'd0);

    // Receive.
    bus.control_in = 3'b010; bus.link_in = {3'd0, 32'hDEAD_BEEF};
    $display("rx src=0 data=0xDEADBEEF");
    step();
    check("rx pulse", 64'(bus.rx_valid), 64'd1);
    check("rx src", 64'(bus.rx_src), 64'd0);
    check("rx data", 64'(bus.rx_data), 64'hDEAD_BEEF);
    check("rx no link", 64'(bus.link_out_valid), 64'd0);
    bus.link_in_valid = 0;
    $display("rx with link idle");
    step();
    check("rx idle", 64'(bus.rx_valid), 64'd0);
    bus.control_in = 3'b000;
    step();

    // Drain the four queued packets.
    for (int i = 0; i < 4; i++) begin
      grant_once();
      step();
    end
    check("drained", 64'(bus.request_out), 64'd0);

    // Self-addressed drop, then an illegal control word.
    push(3'd2, 32'hBAD);
    check("drop pulse", 64'(bus.drop_self), 64'd1);
    step();
    check("drop once", 64'(bus.drop_self), 64'd0);
    check("drop empty", 64'(bus.request_out), 64'd0);
    check("no err yet", 64'(bus.protocol_err), 64'd0);
    bus.control_in = 3'b110;
    $display("illegal control 3'b110");
    step();
    bus.control_in = 3'b000;
    step(); step();
    check("perr sticky", 64'(bus.protocol_err), 64'd1);

    // Starvation, grant clearing it, reset during SEND.
    push(3'd5, 32'h77);
    step();
    check("starve req", 64'(bus.request_out), 64'hD);
    for (int i = 0; i < STV - 1; i++) step();
    check("starve before", 64'(bus.starve), 64'd0);
    step();
    check("starve set", 64'(bus.starve), 64'd1);
    grant_once();
    check("starve cleared", 64'(bus.starve), 64'd0);
    check("send2 valid", 64'(bus.link_out_valid), 64'd1);
    reset = 1'b0;
    $display("reset during send");
    step();
    check("rst tx_ready", 64'(bus.tx_ready), 64'd1);
    check("rst link_v", 64'(bus.link_out_valid), 64'd0);
    check("rst link", 64'(bus.link_out), 64'd0);
    check("rst perr", 64'(bus.protocol_err), 64'd0);
    check("rst req", 64'(bus.request_out), 64'd0);
    reset = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
